timer_service: RTL and testbench
================================

TIMER_SERVICE -- requirements
Module: timer_service

Interface
REQ-001 Parameter MIN_PERIOD, default 3, smallest re-arm interval in cycles; smaller requested periods are clamped up to it.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; latches period and performs the initial arm of the timer.
REQ-005 period  input  32  re-arm interval in cycles; sampled only when start is accepted.
REQ-006 TimerInterrupt  input  1  interrupt line from the memory-mapped timer.
REQ-007 cycle  input  32  read data returned by the timer, combinationally, in the same cycle as the read.
REQ-008 address  output  32  bus address.
REQ-009 data  output  32  bus write data.
REQ-010 MemRead  output  1  bus read strobe.
REQ-011 MemWrite  output  1  bus write strobe.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 ticks  output  32  count of serviced interrupts; wraps modulo 2^32.

Function
REQ-014 The block shall be the bus initiator for the timer: it acknowledges each interrupt, reads the current cycle, and writes the next interrupt cycle.
REQ-015 The FSM states shall be IDLE, ACK, READ and WRITE; each non-IDLE state shall last exactly one cycle.
REQ-016 IDLE: if TimerInterrupt=1 and a period has been latched, go to ACK; else if start=1, latch max(period, MIN_PERIOD) and go to READ; else remain in IDLE.
REQ-017 If TimerInterrupt=1 and start=1 arrive together in IDLE with a period already latched, ACK shall win and start shall be dropped.
REQ-018 ACK shall drive address=32'hffff006c, MemWrite=1, data=0, then go to READ.
REQ-019 READ shall drive address=32'hffff001c and MemRead=1, capture cycle into an internal now register at the clock edge, then go to WRITE.
REQ-020 WRITE shall drive address=32'hffff001c, MemWrite=1 and data=now+latched period (modulo 2^32), then go to IDLE.
REQ-021 ticks shall increment on leaving WRITE only when the sequence entered through ACK; a start-initiated arm shall not increment it.
REQ-022 In IDLE, address, data, MemRead and MemWrite shall all be 0; MemRead and MemWrite shall never be high together.
REQ-023 start pulses received while busy=1 shall be ignored; a sequence in progress always completes.
REQ-024 A TimerInterrupt that asserts during a sequence shall be serviced from IDLE on the cycle after WRITE.
REQ-025 Before the first accepted start, TimerInterrupt shall be ignored, and no bus activity shall occur.
REQ-026 Target arithmetic shall wrap: a now value near 32'hffffffff plus the period shall roll over through 0.

Reset
REQ-027 Reset shall force state=IDLE, busy=0, ticks=0, the now register=0 and the bus outputs to 0, and shall clear the latched-period valid flag.
REQ-028 Reset asserted mid-sequence shall abandon the sequence with no further bus strobes on the following cycle.

Structure
REQ-029 The timer addresses (32'hffff001c, 32'hffff006c), the state encodings and MIN_PERIOD default shall live in the shared defines header.
REQ-030 The latched period, the now register and ticks shall each be an instance of the existing register module; no other sub-module.

Verification
REQ-031 Reset, then start with period=10 while cycle=100 -> READ, then WRITE with data=110, ticks=0, busy low after 2 cycles.
REQ-032 TimerInterrupt=1 with cycle=110 at READ -> ACK write to ffff006c, READ, WRITE data=120, ticks=1.
REQ-033 start with period=1 and cycle=50 -> WRITE data=53 (clamped to MIN_PERIOD).
REQ-034 period=16, cycle=32'hfffffff8 at READ -> WRITE data=32'h00000008.
REQ-035 TimerInterrupt and start together in IDLE after arming -> ACK taken and period unchanged; then reset asserted in READ -> next cycle idle outputs and ticks=0.

Source files
------------

// File: rtl/timer_service_pkg.sv
// Shared definitions for the timer service block: timer bus addresses, FSM
// state encodings, the default minimum re-arm interval, the bus payload struct
// and the period clamp helper.
package timer_service_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DEF_MIN_PERIOD = 3;

    // Memory-mapped timer registers.
    localparam logic [DATA_W-1:0] TIMER_CMP_ADDR = 32'hffff001c;
    localparam logic [DATA_W-1:0] TIMER_ACK_ADDR = 32'hffff006c;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Registered bus strobes and address (write data is produced separately).
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              rd;
        logic              wr;
    } bus_t;

    // Raise a requested period to the minimum re-arm interval.
    function automatic logic [DATA_W-1:0] clamp_period(input logic [DATA_W-1:0] p,
                                                       input int unsigned min_p);
        logic [DATA_W-1:0] lim;
        lim = DATA_W'(min_p);
        return (p < lim) ? lim : p;
    endfunction

endpackage

// File: rtl/timer_service_reg.sv
// Generic enable register with synchronous active-high reset to zero.
// Ports: clock, reset, en (load enable), d (next value), q (stored value).
module timer_service_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/timer_service.sv
// Bus initiator for a memory-mapped timer: arms the compare register on start,
// then on every interrupt acknowledges it, reads the current cycle and writes
// the next compare value (now + period).
// Ports: clock/reset (sync, active-high); start/period arm request;
// TimerInterrupt and cycle (combinational read data) from the timer;
// address/data/MemRead/MemWrite bus master outputs; busy; ticks (serviced IRQs).
module timer_service
    import timer_service_pkg::*;
#(
    parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] period,
    input  logic              TimerInterrupt,
    input  logic [DATA_W-1:0] cycle,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              busy,
    output logic [DATA_W-1:0] ticks
);

    state_e            state_q, state_d;
    bus_t              bus_q, bus_d;
    logic              busy_q, busy_d;
    logic              via_ack_q, via_ack_d;
    logic              per_vld_q, per_vld_d;
    logic              period_en, now_en, ticks_en;
    logic [DATA_W-1:0] period_q, now_q, ticks_q;
    logic [DATA_W-1:0] data_c;

    timer_service_reg #(.WIDTH(DATA_W)) u_period_reg (
        .clock (clock),
        .reset (reset),
        .en    (period_en),
        .d     (clamp_period(period, MIN_PERIOD)),
        .q     (period_q)
    );

    timer_service_reg #(.WIDTH(DATA_W)) u_now_reg (
        .clock (clock),
        .reset (reset),
        .en    (now_en),
        .d     (cycle),
        .q     (now_q)
    );

    timer_service_reg #(.WIDTH(DATA_W)) u_ticks_reg (
        .clock (clock),
        .reset (reset),
        .en    (ticks_en),
        .d     (ticks_q + DATA_W'(1)),
        .q     (ticks_q)
    );

    // Next state; bus strobes are computed for the state being entered so they
    // come straight from flops while that state is current.
    always_comb begin
        state_d   = state_q;
        bus_d     = '0;
        via_ack_d = via_ack_q;
        per_vld_d = per_vld_q;
        period_en = 1'b0;
        now_en    = 1'b0;
        ticks_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Interrupt wins over a simultaneous start; it is ignored
                // until a period has been latched.
                if (TimerInterrupt && per_vld_q) begin
                    state_d   = ST_ACK;
                    via_ack_d = 1'b1;
                    bus_d     = '{addr: TIMER_ACK_ADDR, rd: 1'b0, wr: 1'b1};
                end else if (start) begin
                    state_d   = ST_READ;
                    via_ack_d = 1'b0;
                    per_vld_d = 1'b1;
                    period_en = 1'b1;
                    bus_d     = '{addr: TIMER_CMP_ADDR, rd: 1'b1, wr: 1'b0};
                end
            end
            ST_ACK: begin
                state_d = ST_READ;
                bus_d   = '{addr: TIMER_CMP_ADDR, rd: 1'b1, wr: 1'b0};
            end
            ST_READ: begin
                state_d = ST_WRITE;
                now_en  = 1'b1;
                bus_d   = '{addr: TIMER_CMP_ADDR, rd: 1'b0, wr: 1'b1};
            end
            ST_WRITE: begin
                state_d  = ST_IDLE;
                ticks_en = via_ack_q;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bus_q     <= '0;
            busy_q    <= 1'b0;
            via_ack_q <= 1'b0;
            per_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            busy_q    <= busy_d;
            via_ack_q <= via_ack_d;
            per_vld_q <= per_vld_d;
        end
    end

    // Write data is a decode of flop outputs only: the compare target in WRITE,
    // zero everywhere else (including the ACK write). Addition wraps mod 2^32.
    always_comb begin
        data_c = '0;
        if (state_q == ST_WRITE) begin
            data_c = now_q + period_q;
        end
    end

    assign address  = bus_q.addr;
    assign MemRead  = bus_q.rd;
    assign MemWrite = bus_q.wr;
    assign data     = data_c;
    assign busy     = busy_q;
    assign ticks    = ticks_q;

endmodule

// File: tb/tb_timer_service.sv
// Self-checking bench for timer_service: a table of per-cycle vectors whose
// expected outputs go through a scoreboard queue, plus a hand-written check of
// the arm sequence length.
module tb_timer_service;

    logic        clock = 1'b0;
    logic        reset, start, TimerInterrupt;
    logic [31:0] period, cycle;
    logic [31:0] address, data, ticks;
    logic        MemRead, MemWrite, busy;

    localparam logic [31:0] CMP = 32'hffff001c;
    localparam logic [31:0] ACK = 32'hffff006c;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic        busy;
        logic [31:0] ticks;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        st;
        logic [31:0] per;
        logic        irq;
        logic [31:0] cyc;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    timer_service dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .period         (period),
        .TimerInterrupt (TimerInterrupt),
        .cycle          (cycle),
        .address        (address),
        .data           (data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .busy           (busy),
        .ticks          (ticks)
    );

    always #5 clock = ~clock;

    function automatic obs_t o_idle(input logic [31:0] t);
        return '{address: 32'h0, data: 32'h0, rd: 1'b0, wr: 1'b0, busy: 1'b0, ticks: t};
    endfunction
    function automatic obs_t o_ack(input logic [31:0] t);
        return '{address: ACK, data: 32'h0, rd: 1'b0, wr: 1'b1, busy: 1'b1, ticks: t};
    endfunction
    function automatic obs_t o_read(input logic [31:0] t);
        return '{address: CMP, data: 32'h0, rd: 1'b1, wr: 1'b0, busy: 1'b1, ticks: t};
    endfunction
    function automatic obs_t o_write(input logic [31:0] d, input logic [31:0] t);
        return '{address: CMP, data: d, rd: 1'b0, wr: 1'b1, busy: 1'b1, ticks: t};
    endfunction

    task automatic add(input logic rst, input logic st, input logic [31:0] per,
                       input logic irq, input logic [31:0] cyc, input obs_t e);
        vec_t v;
        v.rst = rst; v.st = st; v.per = per; v.irq = irq; v.cyc = cyc; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = '{address: address, data: data, rd: MemRead, wr: MemWrite, busy: busy, ticks: ticks};
        chk_cnt++;
        if (a === e) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got addr=%h data=%h rd=%b wr=%b busy=%b ticks=%0d, want addr=%h data=%h rd=%b wr=%b busy=%b ticks=%0d",
                     name, a.address, a.data, a.rd, a.wr, a.busy, a.ticks,
                     e.address, e.data, e.rd, e.wr, e.busy, e.ticks);
        end
        chk_cnt++;
        if (!(MemRead && MemWrite)) pass_cnt++;
        else $display("FAIL %s_strobes: got rd=1 wr=1, want not both", name);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; TimerInterrupt = 1'b0; period = '0; cycle = '0;

        // Row inputs are sampled at the next edge; expectations are the outputs after it.
        add(1, 0, 0,   0, 0,            o_idle(0));        // reset
        add(0, 0, 0,   1, 0,            o_idle(0));        // irq before any start ignored
        add(0, 1, 10,  0, 0,            o_read(0));        // arm, period 10
        add(0, 0, 0,   0, 100,          o_write(110, 0));
        add(0, 0, 0,   0, 0,            o_idle(0));
        add(0, 0, 0,   1, 0,            o_ack(0));         // service interrupt
        add(0, 0, 0,   0, 0,            o_read(0));
        add(0, 0, 0,   0, 110,          o_write(120, 0));
        add(0, 0, 0,   0, 0,            o_idle(1));
        add(0, 1, 1,   0, 0,            o_read(1));        // period 1 clamped to 3
        add(0, 0, 0,   0, 50,           o_write(53, 1));
        add(0, 0, 0,   0, 0,            o_idle(1));
        add(0, 1, 16,  0, 0,            o_read(1));        // wrap through zero
        add(0, 0, 0,   0, 32'hfffffff8, o_write(32'h8, 1));
        add(0, 0, 0,   0, 0,            o_idle(1));
        add(0, 1, 100, 1, 0,            o_ack(1));         // irq beats start
        add(0, 1, 200, 0, 0,            o_read(1));        // start while busy ignored
        add(0, 0, 0,   0, 1000,         o_write(1016, 1)); // period still 16
        add(0, 0, 0,   0, 0,            o_idle(2));
        add(0, 1, 5,   0, 0,            o_read(2));
        add(0, 0, 0,   1, 0,            o_write(5, 2));    // irq rises mid-sequence
        add(0, 0, 0,   1, 0,            o_idle(2));        // WRITE completes, arm not counted
        add(0, 0, 0,   1, 0,            o_ack(2));         // serviced from IDLE
        add(0, 0, 0,   0, 0,            o_read(2));
        add(0, 0, 0,   0, 7,            o_write(12, 2));
        add(0, 0, 0,   0, 0,            o_idle(3));
        add(0, 0, 0,   1, 0,            o_ack(3));
        add(0, 0, 0,   0, 0,            o_read(3));
        add(1, 0, 0,   0, 0,            o_idle(0));        // reset in READ
        add(0, 0, 0,   1, 0,            o_idle(0));        // latched period cleared

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            start          = vecs[i].st;
            period         = vecs[i].per;
            TimerInterrupt = vecs[i].irq;
            cycle          = vecs[i].cyc;
            sb.push_back(vecs[i].exp);
            step();
            check($sformatf("vec%0d", i), sb.pop_front());
        end

        // Arm sequence occupies exactly READ and WRITE; bounded wait for idle.
        reset = 1'b0; TimerInterrupt = 1'b0;
        start = 1'b1; period = 32'd3; cycle = 32'd20;
        step();
        start = 1'b0;
        n = 1;
        while (busy && n < 10) begin
            step();
            n++;
        end
        chk_cnt++;
        if (n == 3 && !busy) pass_cnt++;
        else $display("FAIL arm_len: got %0d cycles busy=%b, want 3 cycles busy=0", n, busy);
        chk_cnt++;
        if (ticks == 32'd0) pass_cnt++;
        else $display("FAIL arm_ticks: got %0d, want 0", ticks);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
